// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: receive-side valid/ready bus (master = receiver drives frame + flags, slave = consumer drives ready)
interface uart_rx_param_if #(parameter int DATA_BITS = 8);
  logic                 rx_data_ready;
  logic                 rx_data_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  modport master (input rx_data_ready, output rx_data_valid, rx_data, parity_err, frame_err, overrun);
  modport slave (output rx_data_ready, input rx_data_valid, rx_data, parity_err, frame_err, overrun);
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver; ports clk, rst (sync high), i_rx_pin (async line), bus (uart_rx_param_if.master: one-entry held frame with parity/frame flags and overrun pulse)
module uart_rx_param #(
  parameter int CLK_FRE   = 100,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rx_pin,
  uart_rx_param_if.master bus
);
  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int HALF  = CYCLE / 2;
  localparam int CW    = $clog2(CYCLE);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;
  state_t               r_state;
  logic                 r_s1, r_s;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_bit;
  logic                 r_sb;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr, r_ferr;
  logic                 r_valid, r_pe, r_fe, r_ovr;
  logic [DATA_BITS-1:0] r_data;
  logic                 w_tick, w_ferr, w_done;
  assign w_tick = r_cnt == CW'(CYCLE - 1);
  assign w_ferr = r_ferr | ~r_s;
  assign w_done = (r_state == STOP) && w_tick && (r_sb == 1'(STOP_BITS - 1));
  assign bus.rx_data_valid = r_valid;
  assign bus.rx_data       = r_data;
  assign bus.parity_err    = r_pe;
  assign bus.frame_err     = r_fe;
  assign bus.overrun       = r_ovr;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_s1    <= 1'b1;
      r_s     <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sb    <= 1'b0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pe    <= 1'b0;
      r_fe    <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_s1  <= i_rx_pin;
      r_s   <= r_s1;
      r_ovr <= 1'b0;
      r_cnt <= r_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          r_cnt  <= '0;
          r_bit  <= '0;
          r_sb   <= 1'b0;
          r_perr <= 1'b0;
          r_ferr <= 1'b0;
          if (!r_s) r_state <= START;
        end
        START: if (r_cnt == CW'(HALF - 1)) begin
          r_cnt   <= '0;
          r_state <= r_s ? IDLE : DATA;
        end
        DATA: if (w_tick) begin
          r_cnt   <= '0;
          r_shift <= {r_s, r_shift[DATA_BITS-1:1]};
          r_bit   <= r_bit + 1'b1;
          if (r_bit == 4'(DATA_BITS - 1)) r_state <= (PARITY != 0) ? PAR : STOP;
        end
        PAR: if (w_tick) begin
          r_cnt   <= '0;
          r_perr  <= ^r_shift ^ r_s ^ (PARITY == 1);
          r_state <= STOP;
        end
        STOP: if (w_tick) begin
          r_cnt  <= '0;
          r_ferr <= w_ferr;
          r_sb   <= r_sb + 1'b1;
          if (r_sb == 1'(STOP_BITS - 1)) r_state <= w_ferr ? BRK : IDLE;
        end
        BRK: begin
          r_cnt <= '0;
          if (r_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_done && (!r_valid || bus.rx_data_ready)) begin
        r_valid <= 1'b1;
        r_data  <= r_shift;
        r_pe    <= r_perr;
        r_fe    <= w_ferr;
      end else if (w_done) r_ovr <= 1'b1;
      else if (r_valid && bus.rx_data_ready) r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed checks of an 8N1 and a 7E2 receiver at 10 clocks per bit
module tb_uart_rx_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pin8 = 1'b1, pin7 = 1'b1;
  logic ready8 = 1'b0, ready7 = 1'b0;
  int nchk = 0, nerr = 0;
  int ov8 = 0, fr8 = 0;
  logic prev8 = 1'b0;
  always #5 clk = ~clk;
  uart_rx_param_if #(.DATA_BITS(8)) bus8();
  uart_rx_param_if #(.DATA_BITS(7)) bus7();
  assign bus8.rx_data_ready = ready8;
  assign bus7.rx_data_ready = ready7;
  uart_rx_param #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    d8 (.clk(clk), .rst(rst), .i_rx_pin(pin8), .bus(bus8));
  uart_rx_param #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2))
    d7 (.clk(clk), .rst(rst), .i_rx_pin(pin7), .bus(bus7));
  always @(negedge clk) begin
    if (bus8.overrun) ov8 <= ov8 + 1;
    if (bus8.rx_data_valid && !prev8) fr8 <= fr8 + 1;
    prev8 <= bus8.rx_data_valid;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic send(input bit which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which) pin7 = bits[i]; else pin8 = bits[i];
      tick(10);
    end
    if (which) pin7 = 1'b1; else pin8 = 1'b1;
  endtask
  function automatic logic [15:0] f8(input logic [7:0] d);
    return {7'd0, 1'b1, d, 1'b0};
  endfunction
  function automatic logic [15:0] f7(input logic [6:0] d, input logic p, input logic s2);
    return {5'd0, s2, 1'b1, p, d, 1'b0};
  endfunction
  task automatic consume7();
    ready7 = 1'b1;
    tick(1);
    ready7 = 1'b0;
    chk("consume7_valid", 32'(bus7.rx_data_valid), 0);
  endtask
  initial begin
    int lat, f0, o0;
    logic [7:0] d;
    logic pe, fe, v2;
    tick(3);
    chk("rst_valid", 32'(bus8.rx_data_valid), 0);
    chk("rst_data", 32'(bus8.rx_data), 0);
    chk("rst_perr", 32'(bus8.parity_err), 0);
    chk("rst_ferr", 32'(bus8.frame_err), 0);
    chk("rst_valid7", 32'(bus7.rx_data_valid), 0);
    rst = 1'b0;
    tick(2);
    ready8 = 1'b1;
    lat = 0; d = 0; pe = 1'bx; fe = 1'bx; v2 = 1'bx;
    fork
      send(1'b0, f8(8'hA5), 10);
      for (int k = 1; k <= 200 && lat == 0; k++) begin
        tick(1);
        if (bus8.rx_data_valid) begin
          lat = k; d = bus8.rx_data; pe = bus8.parity_err; fe = bus8.frame_err;
          tick(1);
          v2 = bus8.rx_data_valid;
        end
      end
    join
    ready8 = 1'b0;
    chk("a5_latency", 32'(lat), 98);
    chk("a5_data", 32'(d), 32'hA5);
    chk("a5_perr", 32'(pe), 0);
    chk("a5_ferr", 32'(fe), 0);
    chk("a5_one_valid_cycle", 32'(v2), 0);
    send(1'b1, f7(7'h55, 1'b0, 1'b1), 11);
    tick(5);
    chk("p55_valid", 32'(bus7.rx_data_valid), 1);
    chk("p55_data", 32'(bus7.rx_data), 32'h55);
    chk("p55_perr", 32'(bus7.parity_err), 0);
    chk("p55_ferr", 32'(bus7.frame_err), 0);
    consume7();
    send(1'b1, f7(7'h55, 1'b1, 1'b1), 11);
    tick(5);
    chk("pbad_valid", 32'(bus7.rx_data_valid), 1);
    chk("pbad_perr", 32'(bus7.parity_err), 1);
    chk("pbad_ferr", 32'(bus7.frame_err), 0);
    consume7();
    send(1'b1, f7(7'h55, 1'b0, 1'b0), 11);
    tick(5);
    chk("stop2_valid", 32'(bus7.rx_data_valid), 1);
    chk("stop2_data", 32'(bus7.rx_data), 32'h55);
    chk("stop2_ferr", 32'(bus7.frame_err), 1);
    chk("stop2_perr", 32'(bus7.parity_err), 0);
    consume7();
    f0 = fr8; o0 = ov8;
    pin8 = 1'b0;
    tick(300);
    chk("brk_frames_low", 32'(fr8 - f0), 1);
    chk("brk_overrun_low", 32'(ov8 - o0), 0);
    pin8 = 1'b1;
    tick(30);
    chk("brk_frames_high", 32'(fr8 - f0), 1);
    chk("brk_data", 32'(bus8.rx_data), 0);
    chk("brk_ferr", 32'(bus8.frame_err), 1);
    ready8 = 1'b1; tick(1); ready8 = 1'b0;
    chk("brk_consumed", 32'(bus8.rx_data_valid), 0);
    f0 = fr8; o0 = ov8;
    pin8 = 1'b0; tick(3); pin8 = 1'b1;
    tick(40);
    chk("glitch_frames", 32'(fr8 - f0), 0);
    chk("glitch_overrun", 32'(ov8 - o0), 0);
    chk("glitch_valid", 32'(bus8.rx_data_valid), 0);
    o0 = ov8;
    send(1'b0, f8(8'h11), 10);
    send(1'b0, f8(8'h22), 10);
    tick(5);
    chk("ovr_valid", 32'(bus8.rx_data_valid), 1);
    chk("ovr_data", 32'(bus8.rx_data), 32'h11);
    chk("ovr_pulses", 32'(ov8 - o0), 1);
    o0 = ov8;
    fork
      send(1'b0, f8(8'h33), 10);
      begin
        repeat (97) @(posedge clk);
        #1 ready8 = 1'b1;
        tick(1);
        ready8 = 1'b0;
      end
    join
    tick(3);
    chk("r33_valid", 32'(bus8.rx_data_valid), 1);
    chk("r33_data", 32'(bus8.rx_data), 32'h33);
    chk("r33_no_overrun", 32'(ov8 - o0), 0);
    f0 = fr8;
    fork
      send(1'b0, f8(8'hFF), 10);
      begin
        tick(40);
        rst = 1'b1;
        tick(1);
        chk("midrst_valid", 32'(bus8.rx_data_valid), 0);
        chk("midrst_data", 32'(bus8.rx_data), 0);
        chk("midrst_perr", 32'(bus8.parity_err), 0);
        chk("midrst_ferr", 32'(bus8.frame_err), 0);
        chk("midrst_overrun", 32'(bus8.overrun), 0);
        rst = 1'b0;
      end
    join
    tick(10);
    chk("midrst_abandoned", 32'(bus8.rx_data_valid), 0);
    send(1'b0, f8(8'h3C), 10);
    tick(5);
    chk("c3_valid", 32'(bus8.rx_data_valid), 1);
    chk("c3_data", 32'(bus8.rx_data), 32'h3C);
    chk("c3_ferr", 32'(bus8.frame_err), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
